pic_rd_yuv444: RTL and testbench

Readback engine for the picture RAM. The CPU-side write path packs YUV444 pixels into 16-bit YUV422 words. This block reads those words back over the RAM's CPU port and rebuilds each pixel's 24-bit {Y, Cb, Cr}. It streams the result to the CPU/AXI side with a valid/ready handshake, one burst per start command.

---
 rtl/pic_pkg.sv | 26 ++
 rtl/pic_rd_yuv444.sv | 153 +++++++++++++++
 tb/tb_pic_rd_yuv444.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Picture geometry, 16-bit word lane layout and readback FSM states.
// Shared by the write-side packer and the readback engine.
package pic_pkg;

   localparam int PIC_W      = 320;
   localparam int PIC_H      = 175;
   localparam int PIC_PIXELS = PIC_W * PIC_H;

   localparam int Y_HI = 15;
   localparam int Y_LO = 8;
   localparam int C_HI = 7;
   localparam int C_LO = 0;

   // Even word carries Cb, odd word carries Cr.
   localparam bit CB_ON_EVEN = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_E,
      ISSUE_O,
      WAIT,
      EMIT_E,
      EMIT_O
   } rd_state_t;

endpackage

// File: rtl/pic_rd_yuv444.sv
// Picture RAM readback: rebuilds YUV444 pixels from packed YUV422 words
// and streams them out over a valid/ready handshake.
module pic_rd_yuv444
   import pic_pkg::*;
#(
   parameter int PIC_W  = pic_pkg::PIC_W,
   parameter int PIC_H  = pic_pkg::PIC_H,
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [15:0]       ram_dout,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [23:0]       pix_data,
   output logic              pix_last
);

   localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(PIC_W * PIC_H);

   rd_state_t         st, st_n;
   logic [ADDR_W-1:0] base, rem, addr_q;
   logic [ADDR_W:0]   end_addr;
   logic [1:0]        wcnt;
   logic [1:0]        ev_pipe, od_pipe;
   logic              odd_first;
   logic              accept, reject, hs, ev_cap, od_cap, rem_one;
   logic [7:0]        y_e, y_o, cb, cr;

   assign end_addr  = {1'b0, start_addr} + {1'b0, len};
   assign busy      = (st != IDLE);
   assign accept    = start && !busy && (len != '0) && (end_addr <= NPIX);
   assign reject    = start && !busy && !accept;
   assign pix_valid = (st == EMIT_E) || (st == EMIT_O);
   assign hs        = pix_valid && pix_ready;
   assign rem_one   = (rem == ADDR_W'(1));
   assign pix_last  = pix_valid && rem_one;
   assign ram_en    = (st == ISSUE_E) || (st == ISSUE_O);
   assign ev_cap    = (RD_LAT == 2) ? ev_pipe[1] : ev_pipe[0];
   assign od_cap    = (RD_LAT == 2) ? od_pipe[1] : od_pipe[0];

   // Address mux: holds the last issued address while the RAM is idle.
   always_comb begin
      ram_addr = addr_q;
      if (st == ISSUE_E)
         ram_addr = base;
      else if (st == ISSUE_O)
         ram_addr = {base[ADDR_W-1:1], 1'b1};
   end

   // Pixel rebuild: both pixels of a pair share the stored Cb/Cr.
   always_comb begin
      pix_data = '0;
      if (st == EMIT_E)
         pix_data = {y_e, cb, cr};
      else if (st == EMIT_O)
         pix_data = {y_o, cb, cr};
   end

   // Next-state logic; abort overrides everything outside IDLE.
   always_comb begin
      st_n = st;
      unique case (st)
         IDLE:    if (accept) st_n = ISSUE_E;
         ISSUE_E: st_n = ISSUE_O;
         ISSUE_O: st_n = WAIT;
         WAIT:
            if (wcnt == 2'(RD_LAT - 1))
               st_n = odd_first ? EMIT_O : EMIT_E;
         EMIT_E:  if (hs) st_n = rem_one ? IDLE : EMIT_O;
         EMIT_O:  if (hs) st_n = rem_one ? IDLE : ISSUE_E;
         default: st_n = IDLE;
      endcase
      if (abort && (st != IDLE))
         st_n = IDLE;
   end

   // State register.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n)
         st <= IDLE;
      else
         st <= st_n;
   end

   // Burst bookkeeping: pair base, remaining count and status pulses.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         base      <= '0;
         rem       <= '0;
         addr_q    <= '0;
         wcnt      <= '0;
         odd_first <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done   <= 1'b0;
         err    <= reject;
         addr_q <= ram_addr;
         wcnt   <= (st == WAIT) ? wcnt + 2'd1 : 2'd0;
         if (accept) begin
            base      <= {start_addr[ADDR_W-1:1], 1'b0};
            rem       <= len;
            odd_first <= start_addr[0];
         end
         if ((st == WAIT) && (st_n != WAIT))
            odd_first <= 1'b0;
         if (hs && !abort) begin
            rem <= rem - ADDR_W'(1);
            if (rem_one)
               done <= 1'b1;
            else if (st == EMIT_O)
               base <= base + ADDR_W'(2);
         end
      end
   end

   // Read-return tracking and pair capture.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         ev_pipe <= '0;
         od_pipe <= '0;
         y_e     <= '0;
         y_o     <= '0;
         cb      <= '0;
         cr      <= '0;
      end else begin
         ev_pipe <= {ev_pipe[0], st == ISSUE_E};
         od_pipe <= {od_pipe[0], st == ISSUE_O};
         if (ev_cap) begin
            y_e <= ram_dout[Y_HI:Y_LO];
            if (CB_ON_EVEN) cb <= ram_dout[C_HI:C_LO];
            else            cr <= ram_dout[C_HI:C_LO];
         end
         if (od_cap) begin
            y_o <= ram_dout[Y_HI:Y_LO];
            if (CB_ON_EVEN) cr <= ram_dout[C_HI:C_LO];
            else            cb <= ram_dout[C_HI:C_LO];
         end
      end
   end

endmodule

// File: tb/tb_pic_rd_yuv444.sv
// Bench for pic_rd_yuv444: pixel-level reference model plus directed
// and randomized bursts against a 1-cycle-latency RAM.
module tb_pic_rd_yuv444;

   localparam int NPIX = 320 * 175;

   logic        clk_in = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] start_addr = '0;
   logic [15:0] len = '0;
   logic        abort = 1'b0;
   logic        busy, done, err, ram_en, pix_valid, pix_last;
   logic [15:0] ram_addr;
   logic [15:0] ram_dout = '0;
   logic        pix_ready = 1'b1;
   logic [23:0] pix_data;

   pic_rd_yuv444 #(.PIC_W(320), .PIC_H(175), .ADDR_W(16), .RD_LAT(1)) dut (
      .clk_in(clk_in), .reset_n(reset_n), .start(start),
      .start_addr(start_addr), .len(len), .abort(abort),
      .busy(busy), .done(done), .err(err),
      .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_last(pix_last)
   );

   always #5 clk_in = ~clk_in;

   logic [15:0] mem [0:65535];

   always @(posedge clk_in)
      if (ram_en) ram_dout <= mem[ram_addr];

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] ref_pix(input int p);
      int b;
      logic [15:0] we, wo;
      b  = p - (p % 2);
      we = mem[b];
      wo = mem[b + 1];
      ref_pix = {(p % 2 == 1) ? wo[15:8] : we[15:8], we[7:0], wo[7:0]};
   endfunction

   typedef struct {
      logic [23:0] d;
      bit          last;
   } pix_t;

   pix_t        pq[$];
   int          aq[$];
   logic [23:0] got[$];
   int          reads = 0;
   bit          m_busy, m_err, m_done, stall_q;
   logic [23:0] stall_d;
   logic [15:0] last_addr;
   bit          rand_rdy = 0;

   always @(posedge clk_in) begin
      #1;
      if (rand_rdy) pix_ready = ($urandom_range(0, 3) != 0);
   end

   // Compare process: checks every cycle against the pixel-level model.
   always @(negedge clk_in) begin
      bit n_busy, n_err, n_done;
      int s, n, b0, b1;
      if (!reset_n) begin
         pq.delete(); aq.delete();
         m_busy = 0; m_err = 0; m_done = 0; stall_q = 0;
         last_addr = '0;
      end else begin
         chk("err", err, m_err);
         chk("done", done, m_done);
         chk("busy", busy, m_busy);
         n_busy = m_busy; n_err = 0; n_done = 0;
         if (ram_en) begin
            reads++;
            if (aq.size() == 0) chk("extra_read", 1, 0);
            else chk("ram_addr", ram_addr, aq.pop_front());
         end else begin
            chk("addr_hold", ram_addr, last_addr);
         end
         last_addr = ram_addr;
         if (pix_valid) begin
            if (stall_q) chk("stall_data", pix_data, stall_d);
            if (pq.size() == 0) begin
               chk("extra_pix", 1, 0);
            end else begin
               chk("pix_data", pix_data, pq[0].d);
               chk("pix_last", pix_last, pq[0].last);
               if (pix_ready) begin
                  got.push_back(pix_data);
                  void'(pq.pop_front());
                  if (pq.size() == 0) begin
                     n_done = 1; n_busy = 0;
                     chk("reads_done", aq.size(), 0);
                  end
               end
            end
         end else if (stall_q) begin
            chk("stall_valid", 0, 1);
         end
         stall_q = pix_valid && !pix_ready && !abort;
         stall_d = pix_data;
         if (start && !m_busy) begin
            s = int'(start_addr); n = int'(len);
            if (n == 0 || s + n > NPIX) begin
               n_err = 1;
            end else begin
               n_busy = 1;
               for (int i = 0; i < n; i++)
                  pq.push_back('{ref_pix(s + i), i == n - 1});
               b0 = s - (s % 2);
               b1 = (s + n - 1) - ((s + n - 1) % 2);
               for (int b = b0; b <= b1; b += 2) begin
                  aq.push_back(b); aq.push_back(b + 1);
               end
            end
         end
         if (abort && m_busy) begin
            pq.delete(); aq.delete();
            n_busy = 0; n_done = 0; stall_q = 0;
         end
         m_busy = n_busy; m_err = n_err; m_done = n_done;
      end
   end

   task automatic cyc();
      @(posedge clk_in); #1;
   endtask

   task automatic go(input int s, input int n);
      start = 1; start_addr = 16'(s); len = 16'(n);
      cyc();
      start = 0;
   endtask

   task automatic wait_done(input int max);
      for (int i = 0; i < max; i++) begin
         if (done) return;
         cyc();
      end
      chk("done_timeout", 0, 1);
   endtask

   task automatic wait_valid(input int max);
      for (int i = 0; i < max; i++) begin
         if (pix_valid) return;
         cyc();
      end
      chk("valid_timeout", 0, 1);
   endtask

   task automatic burst(input int s, input int n);
      got.delete();
      go(s, n);
      wait_done(400);
   endtask

   task automatic chk_reset_outs();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_last", pix_last, 0);
      chk("rst_data", pix_data, 0);
   endtask

   initial begin
      int r0, k, s, n;
      logic [23:0] d0;
      for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h4C54; mem[1] = 16'h50FF;
      mem[2] = 16'hE100; mem[3] = 16'hE294;

      repeat (3) cyc();
      chk_reset_outs();
      reset_n = 1;
      cyc();

      got.delete(); r0 = reads;
      start = 1; start_addr = 0; len = 1;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         start = 0;
         if (pix_valid) begin k = i; break; end
      end
      chk("first_latency", k, 4);
      wait_done(50);
      cyc();
      chk("t1_pix", got.size() > 0 ? got[0] : 0, 24'h4C54FF);
      chk("t1_reads", reads - r0, 2);

      r0 = reads;
      burst(1, 1);
      cyc();
      chk("t2_pix", got.size() > 0 ? got[0] : 0, 24'h5054FF);
      chk("t2_reads", reads - r0, 2);

      r0 = reads;
      burst(0, 3);
      cyc();
      chk("t3_n", got.size(), 3);
      if (got.size() == 3) begin
         chk("t3_p0", got[0], 24'h4C54FF);
         chk("t3_p1", got[1], 24'h5054FF);
         chk("t3_p2", got[2], 24'hE10094);
      end
      chk("t3_reads", reads - r0, 4);

      r0 = reads;
      go(55999, 2);
      chk("rej_err", err, 1);
      chk("rej_busy", busy, 0);
      cyc();
      chk("rej_err_clr", err, 0);
      go(10, 0);
      chk("len0_err", err, 1);
      cyc();
      chk("rej_reads", reads - r0, 0);

      pix_ready = 0; got.delete();
      go(0, 2);
      wait_valid(20);
      r0 = reads; d0 = pix_data;
      repeat (5) cyc();
      chk("stall_valid_lit", pix_valid, 1);
      chk("stall_data_lit", pix_data, 24'h4C54FF);
      chk("stall_d0", d0, 24'h4C54FF);
      chk("stall_reads", reads - r0, 0);
      pix_ready = 1;
      wait_done(50);

      go(0, 3);
      repeat (4) cyc();
      abort = 1;
      cyc();
      abort = 0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", pix_valid, 0);
      repeat (2) cyc();
      burst(2, 2);
      cyc();
      chk("ab_n", got.size(), 2);
      if (got.size() == 2) begin
         chk("ab_p0", got[0], 24'hE10094);
         chk("ab_p1", got[1], 24'hE20094);
      end

      burst(0, 1);
      got.delete();
      go(2, 1);
      wait_done(50);
      cyc();
      chk("on_done_pix", got.size() > 0 ? got[0] : 0, 24'hE10094);

      pix_ready = 0;
      go(0, 2);
      wait_valid(20);
      @(posedge clk_in); #3;
      reset_n = 0;
      #1;
      chk_reset_outs();
      pix_ready = 1;
      repeat (2) cyc();
      reset_n = 1;
      cyc();

      rand_rdy = 1;
      for (int it = 0; it < 40; it++) begin
         s = ($urandom_range(0, 4) == 0) ? $urandom_range(NPIX - 16, NPIX - 1)
                                         : $urandom_range(0, NPIX - 1);
         n = $urandom_range(0, 12);
         if (n == 0 || s + n > NPIX) begin
            go(s, n);
            cyc();
         end else begin
            go(s, n);
            start = 1; start_addr = 16'($urandom); len = 16'($urandom);
            cyc();
            start = 0;
            wait_done(600);
            cyc();
         end
      end
      rand_rdy = 0;
      pix_ready = 1;
      repeat (3) cyc();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
